bist_march_ctrl: RTL and testbench

BIST_MARCH_CTRL -- requirements
Module: bist_march_ctrl

---
 rtl/bist_march_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_bist_march_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_march_ctrl.sv
// March C- BIST controller for a single-port SRAM.
// Sequence: E0 up w0, E1 up (r0,w1), E2 up (r1,w0), E3 down (r0,w1),
// E4 down (r1,w0), E5 up r0. One SRAM operation per RUN cycle; the
// read data returns one cycle later and is checked against a pipelined
// expected value. FLUSH exists only to check the final read.
// Optional macro BIST_FAIL_CAPTURE_EN adds first-failure capture outputs
// (address, element number, raw read data).
module bist_march_ctrl #(
    parameter int P_ADDR_WIDTH = 9,
    parameter int P_DATA_WIDTH = 32
) (
    input  logic                    A_BIST_CLK,
    input  logic                    A_BIST_RESET_N,
    input  logic                    BIST_START,
    output logic                    BIST_BUSY,
    output logic                    BIST_DONE,
    output logic                    BIST_FAIL,
    output logic                    A_BIST_EN,
    output logic                    A_BIST_MEN,
    output logic                    A_BIST_WEN,
    output logic                    A_BIST_REN,
    output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
    output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
    input  logic [P_DATA_WIDTH-1:0] A_DOUT
`ifdef BIST_FAIL_CAPTURE_EN
    ,
    output logic [P_ADDR_WIDTH-1:0] BIST_FAIL_ADDR,
    output logic [2:0]              BIST_FAIL_ELEM,
    output logic [P_DATA_WIDTH-1:0] BIST_FAIL_DATA
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    // Element index 6 marks "all operations issued".
    localparam logic [2:0] ELEM_END = 3'd6;

    state_t                  state_q, state_d;
    // Position of the next operation to issue.
    logic [2:0]              elem_q, elem_d;
    logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                    wr_q, wr_d;

    // Registered SRAM-side outputs.
    logic                    en_q, wen_q, ren_q;
    logic [P_ADDR_WIDTH-1:0] sram_addr_q;
    logic [P_DATA_WIDTH-1:0] din_q, bm_q, rd_exp_q;

    // Read-compare pipeline (one cycle behind the read).
    logic                    cmp_vld_q;
    logic [P_DATA_WIDTH-1:0] cmp_data_q;
    logic                    fail_q;
    logic                    mismatch;

    // Operation selection signals.
    logic                    issue, start_clr;
    logic [2:0]              cur_elem, nxt_elem;
    logic [P_ADDR_WIDTH-1:0] cur_addr;
    logic                    cur_wr, is_pair, desc, last_addr, op_write, wr_one, rd_one;

    // Next-state, next-position and operation decode.
    always_comb begin
        state_d   = state_q;
        elem_d    = elem_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        issue     = 1'b0;
        start_clr = 1'b0;
        cur_elem  = elem_q;
        cur_addr  = addr_q;
        cur_wr    = wr_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (BIST_START) begin
                    state_d   = S_RUN;
                    issue     = 1'b1;
                    start_clr = 1'b1;
                    cur_elem  = 3'd0;
                    cur_addr  = '0;
                    cur_wr    = 1'b0;
                end
            end
            S_RUN: begin
                if (elem_q == ELEM_END) state_d = S_FLUSH;
                else                    issue   = 1'b1;
            end
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        is_pair   = (cur_elem >= 3'd1) && (cur_elem <= 3'd4);
        desc      = (cur_elem == 3'd3) || (cur_elem == 3'd4);
        op_write  = (cur_elem == 3'd0) || (is_pair && cur_wr);
        wr_one    = (cur_elem == 3'd1) || (cur_elem == 3'd3);
        rd_one    = (cur_elem == 3'd2) || (cur_elem == 3'd4);
        last_addr = desc ? (cur_addr == '0) : (cur_addr == '1);
        nxt_elem  = cur_elem + 3'd1;

        if (issue) begin
            if (is_pair && !cur_wr) begin
                // Read half of a (r,w) pair: write the same address next.
                elem_d = cur_elem;
                addr_d = cur_addr;
                wr_d   = 1'b1;
            end else if (last_addr) begin
                // Element finished: next element from its own start address.
                elem_d = nxt_elem;
                addr_d = ((nxt_elem == 3'd3) || (nxt_elem == 3'd4)) ? '1 : '0;
                wr_d   = 1'b0;
            end else begin
                elem_d = cur_elem;
                addr_d = desc ? cur_addr - 1'b1 : cur_addr + 1'b1;
                wr_d   = 1'b0;
            end
        end
    end

    assign mismatch = cmp_vld_q && (A_DOUT != cmp_data_q);

    // State, position, SRAM output and compare registers.
    always_ff @(posedge A_BIST_CLK or negedge A_BIST_RESET_N) begin
        if (!A_BIST_RESET_N) begin
            state_q     <= S_IDLE;
            elem_q      <= '0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            en_q        <= 1'b0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            sram_addr_q <= '0;
            din_q       <= '0;
            bm_q        <= '0;
            rd_exp_q    <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_data_q  <= '0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            en_q        <= issue;
            wen_q       <= issue && op_write;
            ren_q       <= issue && !op_write;
            sram_addr_q <= issue ? cur_addr : '0;
            din_q       <= (issue && op_write && wr_one) ? '1 : '0;
            bm_q        <= issue ? '1 : '0;
            rd_exp_q    <= rd_one ? '1 : '0;
            cmp_vld_q   <= ren_q;
            cmp_data_q  <= rd_exp_q;
            if (start_clr)     fail_q <= 1'b0;
            else if (mismatch) fail_q <= 1'b1;
        end
    end

`ifdef BIST_FAIL_CAPTURE_EN
    logic [2:0]              rd_elem_q, cmp_elem_q, fail_elem_q;
    logic [P_ADDR_WIDTH-1:0] cmp_addr_q, fail_addr_q;
    logic [P_DATA_WIDTH-1:0] fail_data_q;

    // Carry element/address alongside the read and latch the first mismatch.
    always_ff @(posedge A_BIST_CLK or negedge A_BIST_RESET_N) begin
        if (!A_BIST_RESET_N) begin
            rd_elem_q   <= '0;
            cmp_elem_q  <= '0;
            cmp_addr_q  <= '0;
            fail_elem_q <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            rd_elem_q  <= cur_elem;
            cmp_elem_q <= rd_elem_q;
            cmp_addr_q <= sram_addr_q;
            if (start_clr) begin
                fail_elem_q <= '0;
                fail_addr_q <= '0;
                fail_data_q <= '0;
            end else if (mismatch && !fail_q) begin
                fail_elem_q <= cmp_elem_q;
                fail_addr_q <= cmp_addr_q;
                fail_data_q <= A_DOUT;
            end
        end
    end

    assign BIST_FAIL_ADDR = fail_addr_q;
    assign BIST_FAIL_ELEM = fail_elem_q;
    assign BIST_FAIL_DATA = fail_data_q;
`endif

    assign BIST_BUSY   = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign BIST_DONE   = (state_q == S_DONE);
    assign BIST_FAIL   = fail_q;
    assign A_BIST_EN   = en_q;
    assign A_BIST_MEN  = en_q;
    assign A_BIST_WEN  = wen_q;
    assign A_BIST_REN  = ren_q;
    assign A_BIST_ADDR = sram_addr_q;
    assign A_BIST_DIN  = din_q;
    assign A_BIST_BM   = bm_q;

endmodule

// File: tb/tb_bist_march_ctrl.sv
// Bench for bist_march_ctrl: a behavioural SRAM with injectable stuck-at
// faults, a March C- operation list built from the algorithm description,
// and a per-cycle compare of every controller output against that list.
module tb_bist_march_ctrl;

    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int N   = 1 << AW;
    localparam int TOT = 10 * N;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy, done, fail, en, men, wen, ren;
    logic [AW-1:0] addr;
    logic [DW-1:0] din, bm;
    logic [DW-1:0] dout;
`ifdef BIST_FAIL_CAPTURE_EN
    logic [AW-1:0] f_addr;
    logic [2:0]    f_elem;
    logic [DW-1:0] f_data;
`endif

    bist_march_ctrl #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW)) dut (
        .A_BIST_CLK     (clk),
        .A_BIST_RESET_N (rst_n),
        .BIST_START     (start),
        .BIST_BUSY      (busy),
        .BIST_DONE      (done),
        .BIST_FAIL      (fail),
        .A_BIST_EN      (en),
        .A_BIST_MEN     (men),
        .A_BIST_WEN     (wen),
        .A_BIST_REN     (ren),
        .A_BIST_ADDR    (addr),
        .A_BIST_DIN     (din),
        .A_BIST_BM      (bm),
        .A_DOUT         (dout)
`ifdef BIST_FAIL_CAPTURE_EN
        ,
        .BIST_FAIL_ADDR (f_addr),
        .BIST_FAIL_ELEM (f_elem),
        .BIST_FAIL_DATA (f_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
            if (nmis >= 50) begin
                $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
                $finish;
            end
        end
    endfunction

    // Fault injection: 0 none, 1 bit5 stuck-at-1 @0x1A5, 2 bit0 stuck-at-0 @0x000.
    int fault_mode = 0;
    function automatic logic [DW-1:0] faulty(logic [AW-1:0] a, logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = v;
        if (fault_mode == 1 && a == 9'h1A5) r[5] = 1'b1;
        if (fault_mode == 2 && a == 9'h000) r[0] = 1'b0;
        return r;
    endfunction

    // Behavioural SRAM with registered read.
    logic [DW-1:0] mem [N];
    always @(posedge clk) begin
        if (men && ren) dout <= faulty(addr, mem[addr]);
        if (men && wen) mem[addr] <= (mem[addr] & ~bm) | (din & bm);
    end

    // Expected operation list, built straight from the March C- description.
    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;   // write data, or expected read data
        int            elem;
    } op_t;
    op_t ops[$];

    task automatic build_ops();
        // per element: down?, has read, read value, has write, write value
        bit el_down[6] = '{0, 0, 0, 1, 1, 0};
        bit el_rd[6]   = '{0, 1, 1, 1, 1, 1};
        bit el_rv[6]   = '{0, 0, 1, 0, 1, 0};
        bit el_wr[6]   = '{1, 1, 1, 1, 1, 0};
        bit el_wv[6]   = '{0, 1, 0, 1, 0, 0};
        op_t o;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < N; k++) begin
                o.a    = el_down[e] ? AW'(N - 1 - k) : AW'(k);
                o.elem = e;
                if (el_rd[e]) begin
                    o.we = 1'b0; o.d = el_rv[e] ? '1 : '0; ops.push_back(o);
                end
                if (el_wr[e]) begin
                    o.we = 1'b1; o.d = el_wv[e] ? '1 : '0; ops.push_back(o);
                end
            end
        end
    endtask

    // Expected first failure for the current fault mode.
    logic          exp_fail;
    logic [AW-1:0] exp_faddr;
    int            exp_felem;
    logic [DW-1:0] exp_fdata;
    task automatic compute_expect();
        exp_fail = 1'b0; exp_faddr = '0; exp_felem = 0; exp_fdata = '0;
        foreach (ops[i]) begin
            if (!exp_fail && !ops[i].we && faulty(ops[i].a, ops[i].d) != ops[i].d) begin
                exp_fail  = 1'b1;
                exp_faddr = ops[i].a;
                exp_felem = ops[i].elem;
                exp_fdata = faulty(ops[i].a, ops[i].d);
            end
        end
    endtask

    // Model phase: 0 idle, 1 running op list, 2 final compare, 3 done.
    int            m_phase;
    int            m_idx;
    logic          m_fail;
    logic [AW-1:0] m_faddr;
    int            m_felem;
    logic [DW-1:0] m_fdata;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_idx   <= 0;
            m_fail  <= 1'b0;
            m_faddr <= '0;
            m_felem <= 0;
            m_fdata <= '0;
        end else begin
            case (m_phase)
                0, 3: if (start) begin
                    m_phase <= 1; m_idx <= 0;
                    m_fail <= exp_fail; m_faddr <= exp_faddr;
                    m_felem <= exp_felem; m_fdata <= exp_fdata;
                end
                1: begin
                    if (m_idx == TOT - 1) m_phase <= 2;
                    else                  m_idx <= m_idx + 1;
                end
                default: m_phase <= 3;
            endcase
        end
    end

    // Recorded DUT operations, for literal spot checks.
    logic [AW-1:0] rec_addr [TOT];
    logic          rec_wen  [TOT];
    logic          rec_ren  [TOT];
    logic [DW-1:0] rec_din  [TOT];

    // Per-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs", {busy, done, fail, en, men, wen, ren, addr, din, bm}, '0);
        end else begin
            logic          run;
            logic          e_we;
            logic [AW-1:0] e_a;
            logic [DW-1:0] e_d;
            run  = (m_phase == 1);
            e_we = run ? ops[m_idx].we : 1'b0;
            e_a  = run ? ops[m_idx].a : '0;
            e_d  = (run && e_we) ? ops[m_idx].d : '0;
            check("cycle_ops",
                  {busy, done, en, men, wen, ren, addr, (wen ? din : (run ? '0 : din))},
                  {(m_phase == 1 || m_phase == 2), (m_phase == 3), run, run,
                   run && e_we, run && !e_we, e_a, e_d});
            if (run) begin
                check("bm_all_ones", bm, {DW{1'b1}});
                rec_addr[m_idx] <= addr;
                rec_wen[m_idx]  <= wen;
                rec_ren[m_idx]  <= ren;
                rec_din[m_idx]  <= din;
            end
            if (m_phase == 0) check("idle_fail", fail, 1'b0);
            if (m_phase == 3) begin
                check("done_fail", fail, m_fail);
`ifdef BIST_FAIL_CAPTURE_EN
                check("done_capture", {f_addr, f_elem, f_data},
                      {m_faddr, 3'(m_felem), m_fdata});
`endif
            end
        end
    end

    // Start a test; optionally re-pulse start mid-run. Returns edge count
    // (start edge = 1) at which DONE is first seen, and BUSY cycle count.
    task automatic run_test(input int extra_at, output int cycles, output int busy_cyc);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        cycles   = 1;
        busy_cyc = busy ? 1 : 0;
        check("start_clears_done_fail", {done, fail}, 2'b00);
        while (done !== 1'b1 && cycles < 6000) begin
            if (cycles == extra_at) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            cycles++;
            if (busy) busy_cyc++;
        end
    endtask

    int cyc, bcyc;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        build_ops();

        // Pin the operation list to hand-derived points.
        check("ops_total", ops.size(), TOT);
        check("ops_first", {ops[0].we, ops[0].a, ops[0].d}, {1'b1, 9'h000, 32'h0});
        check("ops_e3_first", {ops[2560].we, ops[2560].a, ops[2560].d}, {1'b0, 9'h1FF, 32'h0});
        check("ops_e4_last", {ops[4607].we, ops[4607].a, ops[4607].d}, {1'b1, 9'h000, 32'h0});
        check("ops_last", {ops[5119].we, ops[5119].a, ops[5119].d}, {1'b0, 9'h1FF, 32'h0});

        compute_expect();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Fault-free run with a second start pulse mid-run.
        run_test(100, cyc, bcyc);
        check("t1_done_cycle", cyc, 5122);
        check("t1_busy_cycles", bcyc, 5121);
        check("t1_fail", fail, 1'b0);
        check("t1_e3_first_op", {rec_ren[2560], rec_addr[2560]}, {1'b1, 9'h1FF});
        check("t1_e4_last_op", {rec_wen[4607], rec_addr[4607], rec_din[4607]},
              {1'b1, 9'h000, 32'h0});
        repeat (3) @(negedge clk);

        // Bit 5 stuck-at-1 at 0x1A5, started from DONE.
        fault_mode = 1;
        compute_expect();
        check("t2_model_first_fail", {exp_fail, exp_faddr, 3'(exp_felem), exp_fdata},
              {1'b1, 9'h1A5, 3'd1, 32'h0000_0020});
        run_test(-1, cyc, bcyc);
        check("t2_done_cycle", cyc, 5122);
        check("t2_fail", fail, 1'b1);
`ifdef BIST_FAIL_CAPTURE_EN
        check("t2_capture", {f_addr, f_elem, f_data}, {9'h1A5, 3'd1, 32'h0000_0020});
`endif
        repeat (3) @(negedge clk);

        // Bit 0 stuck-at-0 at 0x000.
        fault_mode = 2;
        compute_expect();
        check("t3_model_first_fail", {exp_fail, exp_faddr, 3'(exp_felem), exp_fdata},
              {1'b1, 9'h000, 3'd2, 32'hFFFF_FFFE});
        run_test(-1, cyc, bcyc);
        check("t3_done_cycle", cyc, 5122);
        check("t3_fail", fail, 1'b1);
`ifdef BIST_FAIL_CAPTURE_EN
        check("t3_capture", {f_addr, f_elem, f_data}, {9'h000, 3'd2, 32'hFFFF_FFFE});
`endif
        repeat (3) @(negedge clk);

        // Reset asserted 3000 cycles into RUN, then a fresh test.
        fault_mode = 0;
        compute_expect();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2999) @(posedge clk);
        #2;
        check("t4_busy_before_reset", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t4_async_reset_outputs",
              {busy, done, fail, en, men, wen, ren, addr, din, bm}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t4_idle_after_release", {busy, done, en, wen, ren}, 5'b0);
        run_test(-1, cyc, bcyc);
        check("t4_done_cycle", cyc, 5122);
        check("t4_busy_cycles", bcyc, 5121);
        check("t4_fail", fail, 1'b0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
